// File: rtl/ksa_pkg.sv
// Shared types and helpers for the RC4 key-scheduling stage.
// Holds the state encoding, key geometry and the key-byte selector.
package ksa_pkg;

    localparam int unsigned KEY_BYTES = 3;
    localparam int unsigned ADDR_W    = 8;

    // Last value of the key-byte counter before it wraps back to 0.
    localparam logic [1:0] KIDX_LAST = 2'(KEY_BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StRdI,
        StCapI,
        StRdJ,
        StCapJ,
        StWrI,
        StWrJ
    } state_e;

    // Byte 0 is the most significant byte of the key.
    function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                            input logic [1:0]             idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = key[23:16];
            2'd1:    b = key[15:8];
            default: b = key[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ksa.sv
// RC4 key-scheduling stage: permutes an initialised S-box in place over a
// single-port memory, six cycles per index (read i, read j, write both).
module ksa
    import ksa_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [ADDR_W-1:0]      addr,
    input  logic [7:0]             rddata,
    output logic [7:0]             wrdata,
    output logic                   wren
);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      i_q, i_d;
    logic [ADDR_W-1:0]      j_q, j_d;
    logic [1:0]             kidx_q, kidx_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [7:0]             si_q, si_d;
    logic [7:0]             sj_q, sj_d;
    logic [ADDR_W-1:0]      addr_q;
    logic [7:0]             wrdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            i_q      <= '0;
            j_q      <= '0;
            kidx_q   <= '0;
            key_q    <= '0;
            si_q     <= '0;
            sj_q     <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            kidx_q   <= kidx_d;
            key_q    <= key_d;
            si_q     <= si_d;
            sj_q     <= sj_d;
            addr_q   <= addr;
            wrdata_q <= wrdata;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        kidx_d  = kidx_q;
        key_d   = key_q;
        si_d    = si_q;
        sj_d    = sj_q;
        // Port values persist through idle and capture states.
        addr    = addr_q;
        wrdata  = wrdata_q;
        wren    = 1'b0;
        rdy     = 1'b0;

        case (state_q)
            StIdle: begin
                rdy = 1'b1;
                if (en) begin
                    key_d   = key;
                    i_d     = '0;
                    j_d     = '0;
                    kidx_d  = '0;
                    state_d = StRdI;
                end
            end
            StRdI: begin
                addr    = i_q;
                state_d = StCapI;
            end
            StCapI: begin
                si_d    = rddata;
                j_d     = j_q + rddata + key_byte(key_q, kidx_q);
                state_d = StRdJ;
            end
            StRdJ: begin
                addr    = j_q;
                state_d = StCapJ;
            end
            StCapJ: begin
                sj_d    = rddata;
                state_d = StWrI;
            end
            StWrI: begin
                addr    = i_q;
                wrdata  = sj_q;
                wren    = 1'b1;
                state_d = StWrJ;
            end
            StWrJ: begin
                addr   = j_q;
                wrdata = si_q;
                wren   = 1'b1;
                if (i_q == '1) begin
                    state_d = StIdle;
                end else begin
                    i_d     = i_q + 1'b1;
                    kidx_d  = (kidx_q == KIDX_LAST) ? 2'd0 : kidx_q + 2'd1;
                    state_d = StRdI;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_ksa.sv
// Scoreboard bench for ksa: a software RC4 KSA predicts every memory write and
// the final S-box; monitors compare against the DUT as it produces them.
module tb_ksa;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        rdy;
    logic [23:0] key;
    logic [7:0]  addr;
    logic [7:0]  rddata;
    logic [7:0]  wrdata;
    logic        wren;

    ksa dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .rdy    (rdy),
        .key    (key),
        .addr   (addr),
        .rddata (rddata),
        .wrdata (wrdata),
        .wren   (wren)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port S memory; init_req plays the role of `init`.
    logic [7:0] mem [256];
    logic       init_req;
    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (wren) begin
            mem[addr] <= wrdata;
        end
        rddata <= mem[addr];
    end

    typedef struct packed {
        logic [255:0][7:0] s;
        logic [7:0]        last_addr;
        logic [7:0]        last_data;
    } exp_t;

    exp_t        rq[$];
    logic [15:0] wq[$];
    logic [7:0]  ms [256];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0    = 0;
    bit prev_rdy = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference RC4 KSA on the model array; records each write in order.
    task automatic model(input logic [23:0] k);
        int   j;
        logic [7:0] si, sj;
        exp_t e;
        j = 0;
        for (int i = 0; i < 256; i++) begin
            si = ms[i];
            j  = (j + int'(si) + int'((k >> (8 * (2 - (i % 3)))) & 24'hFF)) % 256;
            sj = ms[j];
            wq.push_back({8'(i), sj});
            wq.push_back({8'(j), si});
            ms[i] = sj;
            ms[j] = si;
            if (i == 255) begin
                e.last_addr = 8'(j);
                e.last_data = si;
            end
        end
        for (int n = 0; n < 256; n++) e.s[n] = ms[n];
        rq.push_back(e);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (en && rdy && rst_n) c0 = cyc;
    end

    // Write monitor: every DUT write must be the next predicted write.
    always @(negedge clk) begin
        if (rst_n && wren) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", {16'h0, addr, wrdata}, 32'hFFFF_FFFF);
            end else begin
                chk("write_addr_data", {16'h0, addr, wrdata}, {16'h0, wq.pop_front()});
            end
            chk("write_phase_ok", 32'(((cyc - c0) % 6) == 4 || ((cyc - c0) % 6) == 5), 32'd1);
        end
    end

    // Completion monitor: rdy rising ends a run.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rdy = 1'b1;
        end else begin
            if (rdy && !prev_rdy) begin
                if (rq.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    int   nmis;
                    e    = rq.pop_front();
                    nmis = 0;
                    for (int n = 0; n < 256; n++) if (mem[n] !== e.s[n]) nmis++;
                    chk("final_sbox_mismatches", 32'(nmis), 32'd0);
                    chk("latency", 32'(cyc - c0), 32'd1536);
                    chk("writes_left", 32'(wq.size()), 32'd0);
                    chk("idle_addr_hold", {24'h0, addr}, {24'h0, e.last_addr});
                    chk("idle_wrdata_hold", {24'h0, wrdata}, {24'h0, e.last_data});
                end
            end
            prev_rdy = rdy;
        end
    end

    task automatic do_init();
        @(negedge clk);
        init_req = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
        for (int n = 0; n < 256; n++) ms[n] = 8'(n);
    endtask

    task automatic start(input logic [23:0] k, input bit b2b);
        if (!b2b) @(negedge clk);
        en  = 1'b1;
        key = k;
        @(posedge clk);
        #1 en = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk);
            if (rdy) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        #1;
    endtask

    task automatic run(input logic [23:0] k, input bit reinit, input bit b2b);
        if (reinit) do_init();
        model(k);
        start(k, b2b);
        wait_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nmis;
        logic [23:0] rk;
        rst_n    = 1'b0;
        en       = 1'b0;
        key      = '0;
        init_req = 1'b0;
        do_init();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset with en low.
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("reset_rdy", {31'h0, rdy}, 32'd1);
            chk("reset_wren", {31'h0, wren}, 32'd0);
            chk("reset_addr", {24'h0, addr}, 32'd0);
        end
        nmis = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== 8'(n)) nmis++;
        chk("reset_mem_untouched", 32'(nmis), 32'd0);

        // Key 0x00033C: iteration 1 swaps S[1] and S[4].
        do_init();
        model(24'h00033C);
        start(24'h00033C, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        chk("iter1_s1", {24'h0, mem[1]}, 32'd4);
        chk("iter1_s4", {24'h0, mem[4]}, 32'd1);
        wait_done();

        // Zero key: i==j at iteration 0, S[2]/S[3] swapped at iteration 2.
        do_init();
        model(24'h000000);
        start(24'h000000, 1'b0);
        repeat (6) @(posedge clk);
        #1 chk("iter0_s0", {24'h0, mem[0]}, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        chk("iter2_s2", {24'h0, mem[2]}, 32'd3);
        chk("iter2_s3", {24'h0, mem[3]}, 32'd2);
        wait_done();

        // en while busy is ignored.
        rk = 24'($urandom);
        do_init();
        model(rk);
        start(rk, 1'b0);
        repeat (100) @(posedge clk);
        @(negedge clk);
        en  = 1'b1;
        key = ~rk;
        @(posedge clk);
        #1 en = 1'b0;
        wait_done();

        // Reset mid-run aborts to idle.
        rk = 24'($urandom);
        do_init();
        model(rk);
        start(rk, 1'b0);
        repeat (699) @(posedge clk);
        #1 rst_n = 1'b0;
        wq.delete();
        rq.delete();
        @(negedge clk);
        chk("abort_rdy", {31'h0, rdy}, 32'd1);
        chk("abort_wren", {31'h0, wren}, 32'd0);
        chk("abort_addr", {24'h0, addr}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run(24'h00033C, 1'b1, 1'b0);

        // Back-to-back start on the rdy-rise cycle, chained on prior output.
        run(24'hFFFFFF, 1'b0, 1'b1);

        for (int r = 0; r < 2; r++) run(24'($urandom), 1'b1, 1'b0);
        run(24'($urandom), 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        chk("queues_empty", 32'(rq.size() + wq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
